// File: rtl/wb_regfile.sv
// Writeback stage and 8 x 16-bit register file with a per-register pending-write scoreboard.
// Optional macro WB_BYPASS_EN adds a write-through path from writeback to the read ports.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int CNT_W  = 2
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [1:0]        WB_OP,
  input  logic [DATA_W-1:0] WB_DATA,
  input  logic [2:0]        WB_DESTREG,
  input  logic [2:0]        RD_ADDR_A,
  input  logic [2:0]        RD_ADDR_B,
  output logic [DATA_W-1:0] RD_DATA_A,
  output logic [DATA_W-1:0] RD_DATA_B,
  input  logic              ISSUE_VALID,
  input  logic              ISSUE_USE_A,
  input  logic              ISSUE_USE_B,
  input  logic              ISSUE_WRITES,
  input  logic [2:0]        ISSUE_DESTREG,
  output logic              STALL,
  output logic [15:0]       INSTR_RETIRED
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  cnt_q  [NREGS];
  logic [CNT_W-1:0]  cnt_d  [NREGS];
  logic [15:0]       retired_q;
  logic [15:0]       retired_d;

  logic commit;
  logic busy_a;
  logic busy_b;
  logic dest_full;
  logic stall;
  logic accept;

  assign commit = ((WB_OP == 2'b01) || (WB_OP == 2'b10)) && (WB_DESTREG != 3'd0);

  // R0 never gets a count because neither accept nor commit can target it.
  always_comb begin
    busy_a    = (cnt_q[RD_ADDR_A] != '0);
    busy_b    = (cnt_q[RD_ADDR_B] != '0);
`ifdef WB_BYPASS_EN
    if (commit && (WB_DESTREG == RD_ADDR_A) && (cnt_q[RD_ADDR_A] == CNT_W'(1)))
      busy_a = 1'b0;
    if (commit && (WB_DESTREG == RD_ADDR_B) && (cnt_q[RD_ADDR_B] == CNT_W'(1)))
      busy_b = 1'b0;
`endif
    dest_full = (ISSUE_DESTREG != 3'd0) &&
                (cnt_q[ISSUE_DESTREG] == {CNT_W{1'b1}}) &&
                !(commit && (WB_DESTREG == ISSUE_DESTREG));
    stall     = ISSUE_VALID && ((ISSUE_USE_A && busy_a) ||
                                (ISSUE_USE_B && busy_b) ||
                                (ISSUE_WRITES && dest_full));
    accept    = ISSUE_VALID && !stall && ISSUE_WRITES && (ISSUE_DESTREG != 3'd0);
  end

  always_comb begin
    RD_DATA_A = regs_q[RD_ADDR_A];
    RD_DATA_B = regs_q[RD_ADDR_B];
`ifdef WB_BYPASS_EN
    if (commit && (WB_DESTREG == RD_ADDR_A))
      RD_DATA_A = WB_DATA;
    if (commit && (WB_DESTREG == RD_ADDR_B))
      RD_DATA_B = WB_DATA;
`endif
  end

  // A simultaneous issue and commit to one register cancel; decrement saturates at zero.
  always_comb begin
    regs_d    = regs_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    if (commit)
      regs_d[WB_DESTREG] = WB_DATA;
    for (int i = 1; i < NREGS; i++) begin
      if (accept && (ISSUE_DESTREG == 3'(i)) && !(commit && (WB_DESTREG == 3'(i))))
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (commit && (WB_DESTREG == 3'(i)) && !(accept && (ISSUE_DESTREG == 3'(i))) &&
               (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
    if (WB_OP != 2'b00)
      retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      regs_q    <= '{default: '0};
      cnt_q     <= '{default: '0};
      retired_q <= '0;
    end else begin
      regs_q    <= regs_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  assign STALL         = stall;
  assign INSTR_RETIRED = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: commit, reads, scoreboard stalls, counters.
// Expectations follow WB_BYPASS_EN when the bench is built with it.
module tb_wb_regfile;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic [1:0]  WB_OP;
  logic [15:0] WB_DATA;
  logic [2:0]  WB_DESTREG;
  logic [2:0]  RD_ADDR_A;
  logic [2:0]  RD_ADDR_B;
  logic [15:0] RD_DATA_A;
  logic [15:0] RD_DATA_B;
  logic        ISSUE_VALID;
  logic        ISSUE_USE_A;
  logic        ISSUE_USE_B;
  logic        ISSUE_WRITES;
  logic [2:0]  ISSUE_DESTREG;
  logic        STALL;
  logic [15:0] INSTR_RETIRED;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_ret = 16'd0;

  wb_regfile dut (
    .CLOCK_50      (CLOCK_50),
    .RESET         (RESET),
    .WB_OP         (WB_OP),
    .WB_DATA       (WB_DATA),
    .WB_DESTREG    (WB_DESTREG),
    .RD_ADDR_A     (RD_ADDR_A),
    .RD_ADDR_B     (RD_ADDR_B),
    .RD_DATA_A     (RD_DATA_A),
    .RD_DATA_B     (RD_DATA_B),
    .ISSUE_VALID   (ISSUE_VALID),
    .ISSUE_USE_A   (ISSUE_USE_A),
    .ISSUE_USE_B   (ISSUE_USE_B),
    .ISSUE_WRITES  (ISSUE_WRITES),
    .ISSUE_DESTREG (ISSUE_DESTREG),
    .STALL         (STALL),
    .INSTR_RETIRED (INSTR_RETIRED)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] dest, input logic [15:0] data);
    WB_OP      = op;
    WB_DESTREG = dest;
    WB_DATA    = data;
    #1;
  endtask

  task automatic setIssue(input logic v, input logic ua, input logic ub, input logic wr,
                          input logic [2:0] dest);
    ISSUE_VALID   = v;
    ISSUE_USE_A   = ua;
    ISSUE_USE_B   = ub;
    ISSUE_WRITES  = wr;
    ISSUE_DESTREG = dest;
    #1;
  endtask

  // Advance one edge; the retired-count model follows the op present at that edge.
  task automatic tick();
    @(posedge CLOCK_50);
    if (WB_OP != 2'b00)
      exp_ret = exp_ret + 16'd1;
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    RD_ADDR_A = 3'd0;
    RD_ADDR_B = 3'd0;
    applyStimulus(2'b00, 3'd0, 16'h0000);
    setIssue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    #10;
    checkOutput("rst_stall", {15'd0, STALL}, 16'd0);
    checkOutput("rst_ret", INSTR_RETIRED, 16'd0);
    RESET = 1'b0;
    tick();

    for (int i = 1; i < 8; i++) begin
      applyStimulus(2'b01, 3'(i), 16'(i * 16'h1111));
      tick();
    end
    applyStimulus(2'b00, 3'd0, 16'h0000);
    for (int i = 1; i < 8; i++) begin
      RD_ADDR_A = 3'(i);
      #1;
      checkOutput($sformatf("fill_r%0d", i), RD_DATA_A, 16'(i * 16'h1111));
    end
    checkOutput("fill_ret", INSTR_RETIRED, 16'd7);

    setIssue(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
    tick();
    RD_ADDR_A = 3'd5;
    RD_ADDR_B = 3'd7;
    setIssue(1'b1, 1'b1, 1'b0, 1'b0, 3'd5);
    checkOutput("pre_rst_stall", {15'd0, STALL}, 16'd1);
    #2 RESET = 1'b1;
    #1;
    checkOutput("mid_rst_a", RD_DATA_A, 16'h0000);
    checkOutput("mid_rst_b", RD_DATA_B, 16'h0000);
    checkOutput("mid_rst_stall", {15'd0, STALL}, 16'd0);
    checkOutput("mid_rst_ret", INSTR_RETIRED, 16'd0);
    exp_ret = 16'd0;
    RESET = 1'b0;
    setIssue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    RD_ADDR_A = 3'd3;
    applyStimulus(2'b01, 3'd3, 16'hBEEF);
`ifdef WB_BYPASS_EN
    checkOutput("beef_same", RD_DATA_A, 16'hBEEF);
`else
    checkOutput("beef_same", RD_DATA_A, 16'h0000);
`endif
    tick();
    applyStimulus(2'b10, 3'd0, 16'h1234);
    checkOutput("beef_next", RD_DATA_A, 16'hBEEF);
    tick();
    applyStimulus(2'b00, 3'd0, 16'h0000);
    RD_ADDR_B = 3'd0;
    #1;
    checkOutput("r0_zero", RD_DATA_B, 16'h0000);

    applyStimulus(2'b01, 3'd5, 16'h5555);
    tick();
    RD_ADDR_A = 3'd5;
    applyStimulus(2'b11, 3'd5, 16'hAAAA);
    tick();
    applyStimulus(2'b00, 3'd0, 16'h0000);
    checkOutput("store_r5", RD_DATA_A, 16'h5555);
    checkOutput("store_ret", INSTR_RETIRED, 16'd4);
    tick();
    checkOutput("bubble_ret", INSTR_RETIRED, 16'd4);

    RD_ADDR_A = 3'd2;
    setIssue(1'b1, 1'b0, 1'b0, 1'b1, 3'd2);
    checkOutput("raw_issue", {15'd0, STALL}, 16'd0);
    tick();
    setIssue(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    checkOutput("raw_stall", {15'd0, STALL}, 16'd1);
    applyStimulus(2'b01, 3'd2, 16'h0042);
`ifdef WB_BYPASS_EN
    checkOutput("raw_commit_stall", {15'd0, STALL}, 16'd0);
    checkOutput("raw_commit_data", RD_DATA_A, 16'h0042);
`else
    checkOutput("raw_commit_stall", {15'd0, STALL}, 16'd1);
    checkOutput("raw_commit_data", RD_DATA_A, 16'h0000);
`endif
    tick();
    applyStimulus(2'b00, 3'd0, 16'h0000);
    checkOutput("raw_after_stall", {15'd0, STALL}, 16'd0);
    checkOutput("raw_after_data", RD_DATA_A, 16'h0042);

    setIssue(1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sat_issue%0d", i), {15'd0, STALL}, 16'd0);
      tick();
    end
    checkOutput("sat_full", {15'd0, STALL}, 16'd1);
    applyStimulus(2'b01, 3'd4, 16'h4444);
    checkOutput("sat_commit", {15'd0, STALL}, 16'd0);
    tick();
    applyStimulus(2'b00, 3'd0, 16'h0000);
    checkOutput("sat_stays3", {15'd0, STALL}, 16'd1);
    setIssue(1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
    RD_ADDR_A = 3'd4;
    #1;
    checkOutput("novalid_stall", {15'd0, STALL}, 16'd0);
    applyStimulus(2'b01, 3'd4, 16'h4444);
    repeat (3) tick();
    applyStimulus(2'b00, 3'd0, 16'h0000);
    setIssue(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    checkOutput("sat_drained", {15'd0, STALL}, 16'd0);

    setIssue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(2'b01, 3'd6, 16'h6666);
    tick();
    applyStimulus(2'b00, 3'd0, 16'h0000);
    RD_ADDR_A = 3'd6;
    RD_ADDR_B = 3'd6;
    setIssue(1'b1, 1'b1, 1'b0, 1'b1, 3'd6);
    checkOutput("uf_data", RD_DATA_A, 16'h6666);
    checkOutput("uf_notbusy", {15'd0, STALL}, 16'd0);
    tick();
    setIssue(1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    checkOutput("uf_busy_after_issue", {15'd0, STALL}, 16'd1);
    checkOutput("pre_wrap_ret", INSTR_RETIRED, 16'd10);

    setIssue(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    applyStimulus(2'b01, 3'd0, 16'h0000);
    while (exp_ret != 16'hFFFF)
      tick();
    applyStimulus(2'b00, 3'd0, 16'h0000);
    checkOutput("ret_ffff", INSTR_RETIRED, 16'hFFFF);
    applyStimulus(2'b01, 3'd0, 16'h0000);
    tick();
    applyStimulus(2'b00, 3'd0, 16'h0000);
    checkOutput("ret_wrap", INSTR_RETIRED, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
